// File: rtl/bram_pkg.sv
// Shared constants and FSM encoding for the dual-port block RAM controller.
package bram_pkg;

    localparam int unsigned RDW_READ_FIRST  = 0;
    localparam int unsigned RDW_WRITE_FIRST = 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } bram_state_t;

endpackage

// File: rtl/bram_port_ctrl.sv
// Per-port front end: accept, range check and the registered read response.
module bram_port_ctrl #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ready,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] rd_word,
    output logic              in_range_c,
    output logic              wr_en_c,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              err
);

    logic accept_c;
    logic rd_en_c;

    always_comb begin
        accept_c   = req && ready;
        in_range_c = 32'(addr) < DEPTH;
        wr_en_c    = accept_c && we && in_range_c;
        rd_en_c    = accept_c && !we;
    end

    // Out-of-range reads complete with zero data; err tracks any out-of-range accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            err    <= 1'b0;
        end else begin
            rvalid <= rd_en_c;
            err    <= accept_c && !in_range_c;
            if (rd_en_c) begin
                rdata <= in_range_c ? rd_word : '0;
            end
        end
    end

endmodule

// File: rtl/bram_dp_ctrl.sv
// Dual-port block RAM controller with power-up clear sweep and write collision arbitration.
module bram_dp_ctrl
    import bram_pkg::*;
#(
    parameter int unsigned       DATA_W         = 10,
    parameter int unsigned       ADDR_W         = 6,
    parameter int unsigned       DEPTH          = 64,
    parameter int unsigned       RDW_MODE       = 0,
    parameter int unsigned       CLEAR_ON_RESET = 1,
    parameter logic [DATA_W-1:0] INIT_VALUE     = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ready,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_err,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ready,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_err,
    output logic              collision,
    output logic              init_busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
    localparam bram_state_t       RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

    logic [DATA_W-1:0] mem [DEPTH];

    bram_state_t       state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              clr_we_c;
    logic              busy_d, ready_d, ready_q;

    logic              a_in_range_c, b_in_range_c;
    logic              a_wr_c, b_wr_c, b_wr_eff_c, same_addr_c;
    logic [DATA_W-1:0] a_rd_word_c, b_rd_word_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RESET_STATE;
            clr_cnt_q <= '0;
            init_busy <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            init_busy <= busy_d;
            ready_q   <= ready_d;
        end
    end

    // Sweep only once init_busy is up, so the busy window is exactly DEPTH cycles.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_we_c  = 1'b0;
        busy_d    = 1'b0;
        ready_d   = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                if (init_busy) begin
                    clr_we_c = 1'b1;
                    if (clr_cnt_q == LAST_ADDR) begin
                        state_d   = ST_RUN;
                        clr_cnt_d = '0;
                    end else begin
                        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                    end
                end
            end
            default: ;
        endcase
        busy_d  = (state_d == ST_CLEAR);
        ready_d = (state_d == ST_RUN);
    end

    assign a_ready = ready_q;
    assign b_ready = ready_q;

    // Port A wins a same-address write; the other port's read sees old or new data by RDW_MODE.
    always_comb begin
        same_addr_c = (a_addr == b_addr);
        b_wr_eff_c  = b_wr_c && !(a_wr_c && same_addr_c);
        a_rd_word_c = a_in_range_c ? mem[a_addr] : '0;
        b_rd_word_c = b_in_range_c ? mem[b_addr] : '0;
        if (RDW_MODE == RDW_WRITE_FIRST) begin
            if (b_wr_eff_c && same_addr_c) a_rd_word_c = b_wdata;
            if (a_wr_c && same_addr_c)     b_rd_word_c = a_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (clr_we_c)   mem[clr_cnt_q] <= INIT_VALUE;
        if (a_wr_c)     mem[a_addr]    <= a_wdata;
        if (b_wr_eff_c) mem[b_addr]    <= b_wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            collision <= 1'b0;
        end else begin
            collision <= a_wr_c && b_wr_c && same_addr_c;
        end
    end

    bram_port_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_port_a (
        .clk        (clk),
        .rst        (rst),
        .ready      (ready_q),
        .req        (a_req),
        .we         (a_we),
        .addr       (a_addr),
        .rd_word    (a_rd_word_c),
        .in_range_c (a_in_range_c),
        .wr_en_c    (a_wr_c),
        .rvalid     (a_rvalid),
        .rdata      (a_rdata),
        .err        (a_err)
    );

    bram_port_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_port_b (
        .clk        (clk),
        .rst        (rst),
        .ready      (ready_q),
        .req        (b_req),
        .we         (b_we),
        .addr       (b_addr),
        .rd_word    (b_rd_word_c),
        .in_range_c (b_in_range_c),
        .wr_en_c    (b_wr_c),
        .rvalid     (b_rvalid),
        .rdata      (b_rdata),
        .err        (b_err)
    );

endmodule

// File: doc/bram_dp_ctrl.md
BRAM_DP_CTRL -- requirements
Module: bram_dp_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DATA_W, 10, word width in bits.
- ADDR_W, 6, address width.
- DEPTH, 64, words implemented; DEPTH <= 2**ADDR_W.
- RDW_MODE, 0, read-during-write: 0 READ_FIRST (old data), 1 WRITE_FIRST (new data).
- CLEAR_ON_RESET, 1, 1 = sweep INIT_VALUE into all words after reset.
- INIT_VALUE, 0, clear pattern, DATA_W bits.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock, rising edge.
- rst, in, 1, asynchronous active-low reset.
- a_req, in, 1, port A request.
- a_we, in, 1, 1 = write, 0 = read.
- a_addr, in, ADDR_W, port A address.
- a_wdata, in, DATA_W, port A write data.
- a_ready, out, 1, port A can accept.
- a_rvalid, out, 1, port A read data valid.
- a_rdata, out, DATA_W, port A read data.
- a_err, out, 1, one-cycle pulse: out-of-range access accepted.
- b_req, b_we, b_addr, b_wdata, b_ready, b_rvalid, b_rdata, b_err: same as port A.
- collision, out, 1, one-cycle pulse: both ports wrote the same address in one cycle.
- init_busy, out, 1, clear sweep in progress.

Function
REQ-003 Accept on a port when req && ready on a rising edge; ready depends only on FSM state, never on req.
REQ-004 FSM states: CLEAR and RUN. Reset release enters CLEAR if CLEAR_ON_RESET=1, otherwise RUN.
REQ-005 CLEAR writes INIT_VALUE to address 0..DEPTH-1, one word per cycle (DEPTH cycles), then enters RUN.
REQ-006 In CLEAR: init_busy=1 and a_ready=b_ready=0. In RUN: init_busy=0 and a_ready=b_ready=1.
REQ-007 Read latency is 1: an accepted read gives rvalid=1 on the next cycle, with rdata = the word at the accepted address.
REQ-008 rvalid is a one-cycle pulse per accepted read; rdata holds its last value until the next read completes; writes never raise rvalid.
REQ-009 Back-to-back reads on a port are supported; each gets its own rvalid cycle, in order.
REQ-010 Same-address write by both ports in one cycle: port A's data is stored, port B's write is dropped, collision pulses on the next cycle.
REQ-011 A read on one port to the address the other port writes in the same cycle returns old data if RDW_MODE=0, else the written data.
REQ-012 Address >= DEPTH: the request is accepted, writes are ignored, reads return zero with rvalid, and the port's err pulses with rvalid (read) or one cycle after accept (write).
REQ-013 Ports are independent: simultaneous reads to any addresses, including the same address, both complete in the same cycle.

Reset
REQ-014 rst low forces asynchronously: a/b_ready=0, a/b_rvalid=0, a/b_rdata=0, a/b_err=0, collision=0, init_busy=0, clear counter=0, FSM=CLEAR (or RUN if CLEAR_ON_RESET=0).
REQ-015 init_busy rises on the first clk edge after rst goes high when CLEAR_ON_RESET=1.
REQ-016 Reset mid-operation discards pending reads (no rvalid follows). Memory contents are undefined until CLEAR completes. Reset during CLEAR restarts the sweep from address 0.
REQ-017 The memory array itself has no reset.

Structure
REQ-018 Shared package bram_pkg holds the RDW_READ_FIRST=0 and RDW_WRITE_FIRST=1 constants and the FSM state encoding.
REQ-019 One sub-module, bram_port_ctrl, instantiated twice, holds the per-port accept, range check, rvalid/rdata/err registers. The array, the clear FSM and collision arbitration stay in the top level.

Verification
REQ-020 Reset, then count cycles -> init_busy high for exactly 64 cycles, ready low throughout, then a_ready=b_ready=1; read address 63 -> rdata=0x000.
REQ-021 A writes 0x2AB to address 5; next cycle A reads address 5 -> a_rvalid one cycle later with a_rdata=0x2AB.
REQ-022 Same cycle: A writes 0x111 to address 9, B writes 0x222 to address 9 -> collision pulses; a later read of address 9 returns 0x111.
REQ-023 A writes 0x3FF to address 7 while B reads address 7, where address 7 held 0x001 -> b_rdata=0x001 if RDW_MODE=0, 0x3FF if RDW_MODE=1.
REQ-024 DEPTH=48: B reads address 50 -> b_rvalid=1, b_rdata=0, b_err pulses; A writes address 60 -> a_err pulses and no stored word changes.
REQ-025 Accept a read, then assert rst in the next cycle -> no rvalid appears; after release the sweep restarts and init_busy stays high for 64 cycles.
